pprm_stage_2_pipe: RTL and testbench

- Pipelined second stage of the 3-stage PPRM inverter.
- Accepts the stage-1 triple (A, B, C) under a valid/ready handshake and computes D = C^-1 in GF(2^4).
- Forwards A, B and D to stage 3 through a registered output with an optional skid buffer, so the S-box datapath can be pipelined and back-pressured.
- Contains no state beyond the pipeline/skid registers.

---
 rtl/pprm_pkg.sv | 27 ++
 rtl/gf16_inv.sv | 20 ++
 rtl/pprm_stage_2_pipe.sv | 96 +++++++++
 tb/tb_pprm_stage_2_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pprm_pkg.sv
// Shared types for the 3-stage PPRM GF(2^4) inverter pipeline.
package pprm_pkg;

  localparam int unsigned GF16_W = 4;
  localparam logic [4:0] GF16_MOD = 5'b10011;

  typedef logic [GF16_W-1:0] gf16_t;

  typedef struct packed {
    gf16_t a;
    gf16_t b;
  } pprm_ab_t;

  // Payload held in the stage-2 pipeline and skid registers
  typedef struct packed {
    pprm_ab_t ab;
    gf16_t    c;
    gf16_t    d;
  } pprm_s2_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/gf16_inv.sv
// Combinational GF(2^4) inverse (modulus x^4+x+1, inv(0)=0) in XOR-of-AND form.
module gf16_inv (
  input  logic [3:0] c_i,
  output logic [3:0] d_o
);

  logic c0, c1, c2, c3;

  assign {c3, c2, c1, c0} = c_i;

  assign d_o[0] = c0 ^ c1 ^ c2 ^ c3 ^ (c0 & c2) ^ (c1 & c2)
                ^ (c0 & c1 & c2) ^ (c1 & c2 & c3);
  assign d_o[1] = c3 ^ (c0 & c1) ^ (c0 & c2) ^ (c1 & c2) ^ (c1 & c3)
                ^ (c0 & c1 & c3);
  assign d_o[2] = c2 ^ c3 ^ (c0 & c1) ^ (c0 & c2) ^ (c0 & c3)
                ^ (c0 & c2 & c3);
  assign d_o[3] = c1 ^ c2 ^ c3 ^ (c0 & c3) ^ (c1 & c3) ^ (c2 & c3)
                ^ (c1 & c2 & c3);

endmodule

// File: rtl/pprm_stage_2_pipe.sv
// Stage 2 of the PPRM inverter: D = inv(C), forwarded with A/B through a
// valid/ready output register plus optional skid entry.
module pprm_stage_2_pipe
  import pprm_pkg::*;
#(
  parameter bit SKID   = 1'b1,
  parameter bit PASS_C = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [3:0] in_c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic [3:0] out_d,
  output logic [3:0] out_c,
  output logic [1:0] occupancy
);

  gf16_t    in_d;
  pprm_s2_t in_beat;
  pprm_s2_t main_q, main_d;
  pprm_s2_t skid_q, skid_d;
  occ_e     occ_q, occ_d;
  logic     in_xfer;
  logic     out_xfer;

  gf16_inv u_inv (
    .c_i (in_c),
    .d_o (in_d)
  );

  assign in_beat = pprm_s2_t'({in_a, in_b, in_c, in_d});

  assign out_valid = (occ_q != OCC_EMPTY);
  // With a skid entry, ready depends only on registered occupancy
  assign in_ready  = !rst && (SKID ? (occ_q != OCC_FULL) : (!out_valid || out_ready));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Occupancy transitions; ONE with input only is unreachable without a skid entry
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (in_xfer) begin
          main_d = in_beat;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_beat;
        end else if (in_xfer) begin
          skid_d = in_beat;
          occ_d  = OCC_FULL;
        end else if (out_xfer) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (out_xfer) begin
          main_d = skid_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_a     = main_q.ab.a;
  assign out_b     = main_q.ab.b;
  assign out_d     = main_q.d;
  assign out_c     = PASS_C ? main_q.c : 4'h0;
  assign occupancy = 2'(occ_q);

endmodule

// File: tb/tb_pprm_stage_2_pipe.sv
// Bench for pprm_stage_2_pipe: FIFO-style reference model for a skid and a
// no-skid instance plus directed vectors with hand-computed results.
module tb_pprm_stage_2_pipe;
  import pprm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] in_a = 4'h0, in_b = 4'h0, in_c = 4'h0;

  logic       s_in_ready, s_out_valid;
  logic [3:0] s_out_a, s_out_b, s_out_d, s_out_c;
  logic [1:0] s_occ;
  logic       n_in_ready, n_out_valid;
  logic [3:0] n_out_a, n_out_b, n_out_d, n_out_c;
  logic [1:0] n_occ;

  pprm_stage_2_pipe #(.SKID(1'b1), .PASS_C(1'b0)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_a(s_out_a), .out_b(s_out_b), .out_d(s_out_d),
    .out_c(s_out_c), .occupancy(s_occ)
  );

  pprm_stage_2_pipe #(.SKID(1'b0), .PASS_C(1'b1)) u_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_a(n_out_a), .out_b(n_out_b), .out_d(n_out_d),
    .out_c(n_out_c), .occupancy(n_occ)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] inv_tab [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                               4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Field multiply by shift-and-reduce; inverse found by search
  function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y);
    logic [4:0] t;
    logic [3:0] r;
    t = {1'b0, x};
    r = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) r = r ^ t[3:0];
      t = t << 1;
      if (t[4]) t = t ^ GF16_MOD;
    end
    return r;
  endfunction

  function automatic logic [3:0] ginv(input logic [3:0] c);
    for (int k = 1; k < 16; k++) begin
      if (gmul(c, 4'(k)) == 4'h1) return 4'(k);
    end
    return 4'h0;
  endfunction

  // Reference: each instance is an in-order FIFO of depth 2 (skid) or 1 (no skid)
  logic [15:0] qs[$];
  logic [15:0] qn[$];
  logic        armed = 1'b0;
  bit          m_rs, m_rn, m_vs, m_vn;

  always @(posedge clk) begin
    if (rst) begin
      qs.delete();
      qn.delete();
      armed <= 1'b1;
    end else begin
      m_rs = (qs.size() < 2);
      m_vs = (qs.size() != 0);
      m_rn = (qn.size() == 0) || out_ready;
      m_vn = (qn.size() != 0);
      if (m_vs && out_ready) void'(qs.pop_front());
      if (in_valid && m_rs) qs.push_back({in_a, in_b, in_c, ginv(in_c)});
      if (m_vn && out_ready) void'(qn.pop_front());
      if (in_valid && m_rn) qn.push_back({in_a, in_b, in_c, ginv(in_c)});
    end
  end

  logic [15:0] es, en;

  always @(negedge clk) begin
    if (armed) begin
      chk("s_in_ready", 32'(s_in_ready), 32'(!rst && qs.size() < 2));
      chk("s_out_valid", 32'(s_out_valid), 32'(qs.size() != 0));
      chk("s_occupancy", 32'(s_occ), 32'(qs.size()));
      if (qs.size() != 0) begin
        es = qs[0];
        chk("s_out_a", 32'(s_out_a), 32'(es[15:12]));
        chk("s_out_b", 32'(s_out_b), 32'(es[11:8]));
        chk("s_out_d", 32'(s_out_d), 32'(es[3:0]));
        chk("s_out_c", 32'(s_out_c), 32'h0);
      end
      chk("n_in_ready", 32'(n_in_ready), 32'(!rst && (qn.size() == 0 || out_ready)));
      chk("n_out_valid", 32'(n_out_valid), 32'(qn.size() != 0));
      chk("n_occupancy", 32'(n_occ), 32'(qn.size()));
      if (qn.size() != 0) begin
        en = qn[0];
        chk("n_out_a", 32'(n_out_a), 32'(en[15:12]));
        chk("n_out_b", 32'(n_out_b), 32'(en[11:8]));
        chk("n_out_c", 32'(n_out_c), 32'(en[7:4]));
        chk("n_out_d", 32'(n_out_d), 32'(en[3:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ra, rb, rc;

  initial begin
    for (int i = 0; i < 16; i++) chk("model_inv", 32'(ginv(4'(i))), 32'(inv_tab[i]));

    // Reset, then a single beat
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("rst_out_valid", 32'(s_out_valid), 32'h0);
    chk("rst_occ", 32'(s_occ), 32'h0);
    chk("rst_out_a", 32'(s_out_a), 32'h0);
    chk("rst_out_b", 32'(s_out_b), 32'h0);
    chk("rst_out_d", 32'(s_out_d), 32'h0);
    chk("rst_n_out_c", 32'(n_out_c), 32'h0);
    chk("rst_in_ready", 32'(s_in_ready), 32'h0);
    tick();
    rst = 1'b0; in_valid = 1'b1; in_a = 4'h3; in_b = 4'h5; in_c = 4'h2;
    #1;
    chk("t1_in_ready", 32'(s_in_ready), 32'h1);
    tick();
    chk("t1_out_valid", 32'(s_out_valid), 32'h1);
    chk("t1_out_a", 32'(s_out_a), 32'h3);
    chk("t1_out_b", 32'(s_out_b), 32'h5);
    chk("t1_out_d", 32'(s_out_d), 32'h9);
    in_valid = 1'b0;
    tick();
    chk("t1_drain_valid", 32'(s_out_valid), 32'h0);
    chk("t1_drain_occ", 32'(s_occ), 32'h0);

    // Every C back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_a = 4'(i); in_b = 4'(15 - i); in_c = 4'(i);
      tick();
      chk("t2_valid", 32'(s_out_valid), 32'h1);
      chk("t2_s_d", 32'(s_out_d), 32'(inv_tab[i]));
      chk("t2_n_d", 32'(n_out_d), 32'(inv_tab[i]));
    end
    in_valid = 1'b0;
    tick();
    chk("t2_occ", 32'(s_occ), 32'h0);

    // Backpressure into the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_a = 4'h1; in_b = 4'h2; in_c = 4'h4;
    tick();
    in_c = 4'h8;
    tick();
    chk("t3_occ_full", 32'(s_occ), 32'h2);
    in_c = 4'hA;
    #1;
    chk("t3_in_ready_full", 32'(s_in_ready), 32'h0);
    chk("t3_head_d", 32'(s_out_d), 32'hD);
    tick();
    chk("t3_hold_d", 32'(s_out_d), 32'hD);
    chk("t3_hold_occ", 32'(s_occ), 32'h2);
    out_ready = 1'b1;
    #1;
    chk("t3_ready_registered", 32'(s_in_ready), 32'h0);
    tick();
    chk("t3_second_d", 32'(s_out_d), 32'hF);
    chk("t3_in_ready_back", 32'(s_in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("t3_third_d", 32'(s_out_d), 32'hC);
    tick();
    chk("t3_empty", 32'(s_occ), 32'h0);

    // Simultaneous in/out at occupancy 1
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      in_valid = 1'b1; in_a = ra; in_b = rb; in_c = rc;
      tick();
      chk("t4_occ", 32'(s_occ), 32'h1);
      chk("t4_a", 32'(s_out_a), 32'(ra));
      chk("t4_b", 32'(s_out_b), 32'(rb));
      chk("t4_d", 32'(s_out_d), 32'(inv_tab[rc]));
    end
    in_valid = 1'b0;
    tick();

    // Reset while full
    out_ready = 1'b0; in_valid = 1'b1; in_c = 4'h1;
    tick();
    in_c = 4'h3;
    tick();
    chk("t5_occ_full", 32'(s_occ), 32'h2);
    rst = 1'b1;
    #1;
    chk("t5_ready_in_rst", 32'(s_in_ready), 32'h0);
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("t5_valid", 32'(s_out_valid), 32'h0);
    chk("t5_occ", 32'(s_occ), 32'h0);
    chk("t5_ready_after", 32'(s_in_ready), 32'h1);
    tick();
    chk("t5_no_stale", 32'(s_out_valid), 32'h0);

    // No-skid instance: combinational ready and C pass-through
    out_ready = 1'b0; in_valid = 1'b1; in_a = 4'h1; in_b = 4'h2; in_c = 4'h7;
    tick();
    in_a = 4'h4; in_b = 4'h5; in_c = 4'hE;
    #1;
    chk("t6_n_valid", 32'(n_out_valid), 32'h1);
    chk("t6_n_ready_low", 32'(n_in_ready), 32'h0);
    chk("t6_n_occ", 32'(n_occ), 32'h1);
    tick();
    out_ready = 1'b1;
    #1;
    chk("t6_n_ready_comb", 32'(n_in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("t6_n_out_c", 32'(n_out_c), 32'hE);
    chk("t6_n_out_d", 32'(n_out_d), 32'h3);
    chk("t6_n_out_a", 32'(n_out_a), 32'h4);
    chk("t6_s_out_c", 32'(s_out_c), 32'h0);
    tick();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
